// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch-stage program-counter logic.
//   state_t            : PC generator FSM encoding (BOOT / RUN / HALT)
//   align_bits()       : log2 of the instruction size, i.e. the number of low
//                        target bits that must be zero for an aligned fetch
package cpu_pkg;

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   // Smallest r with 2**r >= bytes; exact log2 for power-of-two sizes.
   function automatic int align_bits(input int bytes);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < bytes) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/pc_incr.sv
// Sequential-address adder for the fetch stage: pc_o = pc_i + INSTR_BYTES,
// wrapping modulo 2**ADDR_WIDTH. Kept as its own block so a faster adder
// structure can replace it without touching the PC control logic.
//   pc_i  in  ADDR_WIDTH  current PC
//   pc_o  out ADDR_WIDTH  PC + INSTR_BYTES
module pc_incr #(
   parameter int ADDR_WIDTH  = 32,
   parameter int INSTR_BYTES = 4
) (
   input  logic [ADDR_WIDTH-1:0] pc_i,
   output logic [ADDR_WIDTH-1:0] pc_o
);

   assign pc_o = pc_i + ADDR_WIDTH'(INSTR_BYTES);

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator for the fetch stage. Holds the PC, selects the
// next fetch address (pending > jump > branch > sequential), buffers one
// redirect across a stall, supports halt/resume and traps misaligned targets.
//   clk, rst_n                     clock, async active-low reset
//   stall                          hold the PC this cycle
//   branch_taken / branch_target   branch redirect
//   jump / jump_target             jump redirect (beats branch)
//   halt_req / resume              enter / leave HALT
//   pc_addr                        registered fetch address
//   pc_seq                         pc_addr + INSTR_BYTES (combinational)
//   pc_valid                       pc_addr is a fetch to be executed
//   trap / trap_epc                one-cycle misaligned-redirect pulse + target
//   pend_valid                     a redirect is buffered during a stall
//
// state | meaning
// BOOT  | first cycle after reset release, PC held, no fetch
// RUN   | fetching, PC advances unless stalled
// HALT  | PC held, no fetch, redirects ignored until resume
module pc_gen
   import cpu_pkg::*;
#(
   parameter int                    ADDR_WIDTH   = 32,
   parameter int                    INSTR_BYTES  = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 'h0000_0000,
   parameter logic [ADDR_WIDTH-1:0] TRAP_VECTOR  = 'h0000_0080
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  stall,
   input  logic                  branch_taken,
   input  logic [ADDR_WIDTH-1:0] branch_target,
   input  logic                  jump,
   input  logic [ADDR_WIDTH-1:0] jump_target,
   input  logic                  halt_req,
   input  logic                  resume,
   output logic [ADDR_WIDTH-1:0] pc_addr,
   output logic [ADDR_WIDTH-1:0] pc_seq,
   output logic                  pc_valid,
   output logic                  trap,
   output logic [ADDR_WIDTH-1:0] trap_epc,
   output logic                  pend_valid
);

   localparam int ALIGN_BITS = align_bits(INSTR_BYTES);
   // All-zero when INSTR_BYTES is 1, so no target can ever be misaligned.
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((1 << ALIGN_BITS) - 1);

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
   logic                    valid_q, valid_d;
   logic                    pend_valid_q, pend_valid_d;
   logic [ADDR_WIDTH-1:0]   pend_tgt_q, pend_tgt_d;
   logic                    trap_q, trap_d;
   logic [ADDR_WIDTH-1:0]   epc_q, epc_d;

   logic [ADDR_WIDTH-1:0]   pc_seq_w;
   logic                    redir;
   logic [ADDR_WIDTH-1:0]   redir_tgt;
   logic                    apply;
   logic [ADDR_WIDTH-1:0]   apply_tgt;

   pc_incr #(
      .ADDR_WIDTH  (ADDR_WIDTH),
      .INSTR_BYTES (INSTR_BYTES)
   ) u_pc_incr (
      .pc_i (pc_q),
      .pc_o (pc_seq_w)
   );

   assign redir     = jump | branch_taken;
   assign redir_tgt = jump ? jump_target : branch_target;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      valid_d      = valid_q;
      pend_valid_d = pend_valid_q;
      pend_tgt_d   = pend_tgt_q;
      trap_d       = 1'b0;
      epc_d        = epc_q;
      apply        = 1'b0;
      apply_tgt    = pc_seq_w;

      case (state_q)
         ST_BOOT: begin
            state_d = ST_RUN;
            valid_d = 1'b1;
         end
         ST_RUN: begin
            if (stall) begin
               // Only the first redirect of a stall window is kept.
               if (redir && !pend_valid_q) begin
                  pend_valid_d = 1'b1;
                  pend_tgt_d   = redir_tgt;
               end
            end else begin
               // A buffered redirect shadows anything arriving this cycle.
               if (pend_valid_q) begin
                  apply        = 1'b1;
                  apply_tgt    = pend_tgt_q;
                  pend_valid_d = 1'b0;
               end else if (redir) begin
                  apply     = 1'b1;
                  apply_tgt = redir_tgt;
               end

               if (apply && ((apply_tgt & ALIGN_MASK) != '0)) begin
                  pc_d   = TRAP_VECTOR;
                  trap_d = 1'b1;
                  epc_d  = apply_tgt;
               end else begin
                  pc_d = apply_tgt;
               end

               // Halt takes effect after this final advance.
               if (halt_req) begin
                  state_d = ST_HALT;
                  valid_d = 1'b0;
               end
            end
         end
         ST_HALT: begin
            if (resume) begin
               state_d = ST_RUN;
               valid_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_BOOT;
            valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_BOOT;
         pc_q         <= RESET_VECTOR;
         valid_q      <= 1'b0;
         pend_valid_q <= 1'b0;
         pend_tgt_q   <= '0;
         trap_q       <= 1'b0;
         epc_q        <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         valid_q      <= valid_d;
         pend_valid_q <= pend_valid_d;
         pend_tgt_q   <= pend_tgt_d;
         trap_q       <= trap_d;
         epc_q        <= epc_d;
      end
   end

   assign pc_addr    = pc_q;
   assign pc_seq     = pc_seq_w;
   assign pc_valid   = valid_q;
   assign trap       = trap_q;
   assign trap_epc   = epc_q;
   assign pend_valid = pend_valid_q;

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall, branch_taken, jump, halt_req, resume;
   logic [31:0] branch_target, jump_target;
   logic [31:0] pc_addr, pc_seq, trap_epc;
   logic        pc_valid, trap, pend_valid;

   logic        z1 = 1'b0;
   logic [7:0]  z8 = 8'h00;
   logic [7:0]  pc8, seq8, epc8;
   logic        valid8, trap8, pend8;

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   pc_gen #(.ADDR_WIDTH(32), .INSTR_BYTES(4), .RESET_VECTOR(32'h0), .TRAP_VECTOR(32'h80)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .jump(jump), .jump_target(jump_target),
      .halt_req(halt_req), .resume(resume),
      .pc_addr(pc_addr), .pc_seq(pc_seq), .pc_valid(pc_valid),
      .trap(trap), .trap_epc(trap_epc), .pend_valid(pend_valid)
   );

   pc_gen #(.ADDR_WIDTH(8), .INSTR_BYTES(4), .RESET_VECTOR(8'hF8), .TRAP_VECTOR(8'h80)) dut8 (
      .clk(clk), .rst_n(rst_n), .stall(z1),
      .branch_taken(z1), .branch_target(z8),
      .jump(z1), .jump_target(z8),
      .halt_req(z1), .resume(z1),
      .pc_addr(pc8), .pc_seq(seq8), .pc_valid(valid8),
      .trap(trap8), .trap_epc(epc8), .pend_valid(pend8)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      stall = 0; branch_taken = 0; jump = 0; halt_req = 0; resume = 0;
      branch_target = 32'h0; jump_target = 32'h0;
   endtask

   // Leaves both DUTs in RUN at their reset vector.
   task automatic do_reset();
      clear_in();
      rst_n = 0;
      tick();
      tick();
      rst_n = 1;
      tick();
   endtask

   task automatic test_reset();
      logic [31:0] exp_pc [4];
      exp_pc = '{32'h0, 32'h4, 32'h8, 32'hC};
      clear_in();
      rst_n = 0;
      tick();
      total_cnt++; if (pc_addr !== 32'h0) $display("FAIL reset_pc: got %h expected %h", pc_addr, 32'h0); else pass_cnt++;
      total_cnt++; if (pc_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", pc_valid); else pass_cnt++;
      total_cnt++; if (trap !== 1'b0 || trap_epc !== 32'h0) $display("FAIL reset_trap: got %b/%h expected 0/0", trap, trap_epc); else pass_cnt++;
      total_cnt++; if (pend_valid !== 1'b0) $display("FAIL reset_pend: got %b expected 0", pend_valid); else pass_cnt++;
      rst_n = 1;
      #2;
      total_cnt++; if (pc_valid !== 1'b0 || pc_addr !== 32'h0) $display("FAIL boot: got %b/%h expected 0/0", pc_valid, pc_addr); else pass_cnt++;
      for (int i = 0; i < 4; i++) begin
         tick();
         total_cnt++;
         if (pc_addr !== exp_pc[i] || pc_valid !== 1'b1)
            $display("FAIL run_seq[%0d]: got %h/%b expected %h/1", i, pc_addr, pc_valid, exp_pc[i]);
         else pass_cnt++;
      end
   endtask

   task automatic test_branch();
      do_reset();
      tick(); tick();
      total_cnt++; if (pc_addr !== 32'h8) $display("FAIL pre_branch: got %h expected %h", pc_addr, 32'h8); else pass_cnt++;
      branch_taken = 1; branch_target = 32'h100;
      tick();
      clear_in();
      total_cnt++; if (pc_addr !== 32'h100) $display("FAIL branch: got %h expected %h", pc_addr, 32'h100); else pass_cnt++;
      total_cnt++; if (pc_seq !== 32'h104) $display("FAIL pc_seq: got %h expected %h", pc_seq, 32'h104); else pass_cnt++;
      tick();
      total_cnt++; if (pc_addr !== 32'h104) $display("FAIL post_branch: got %h expected %h", pc_addr, 32'h104); else pass_cnt++;
   endtask

   task automatic test_jump_branch();
      jump = 1; jump_target = 32'h40;
      branch_taken = 1; branch_target = 32'h300;
      tick();
      clear_in();
      total_cnt++; if (pc_addr !== 32'h40) $display("FAIL jump_over_branch: got %h expected %h", pc_addr, 32'h40); else pass_cnt++;
   endtask

   task automatic test_stall();
      do_reset();
      stall = 1; jump = 1; jump_target = 32'h200;
      tick();
      total_cnt++; if (pc_addr !== 32'h0 || pend_valid !== 1'b1) $display("FAIL stall1: got %h/%b expected 0/1", pc_addr, pend_valid); else pass_cnt++;
      jump = 0; branch_taken = 1; branch_target = 32'h300;
      tick();
      total_cnt++; if (pc_addr !== 32'h0) $display("FAIL stall2: got %h expected %h", pc_addr, 32'h0); else pass_cnt++;
      branch_taken = 0;
      tick();
      total_cnt++; if (pc_addr !== 32'h0 || pend_valid !== 1'b1) $display("FAIL stall3: got %h/%b expected 0/1", pc_addr, pend_valid); else pass_cnt++;
      stall = 0; branch_taken = 1; branch_target = 32'h500;
      tick();
      clear_in();
      total_cnt++; if (pc_addr !== 32'h200 || pend_valid !== 1'b0) $display("FAIL pend_apply: got %h/%b expected 200/0", pc_addr, pend_valid); else pass_cnt++;
      tick();
      total_cnt++; if (pc_addr !== 32'h204) $display("FAIL post_pend: got %h expected %h", pc_addr, 32'h204); else pass_cnt++;
   endtask

   task automatic test_trap();
      jump = 1; jump_target = 32'h102;
      tick();
      clear_in();
      total_cnt++; if (pc_addr !== 32'h80 || trap !== 1'b1) $display("FAIL trap_jump: got %h/%b expected 80/1", pc_addr, trap); else pass_cnt++;
      total_cnt++; if (trap_epc !== 32'h102) $display("FAIL trap_epc: got %h expected %h", trap_epc, 32'h102); else pass_cnt++;
      tick();
      total_cnt++; if (trap !== 1'b0 || pc_addr !== 32'h84) $display("FAIL trap_pulse: got %b/%h expected 0/84", trap, pc_addr); else pass_cnt++;
      stall = 1; branch_taken = 1; branch_target = 32'h206;
      tick();
      branch_taken = 0;
      tick();
      total_cnt++; if (pc_addr !== 32'h84) $display("FAIL trap_pend_hold: got %h expected %h", pc_addr, 32'h84); else pass_cnt++;
      stall = 0;
      tick();
      total_cnt++; if (pc_addr !== 32'h80 || trap !== 1'b1 || trap_epc !== 32'h206)
         $display("FAIL trap_pend: got %h/%b/%h expected 80/1/206", pc_addr, trap, trap_epc);
      else pass_cnt++;
   endtask

   task automatic test_halt();
      do_reset();
      tick(); tick(); tick(); tick();
      total_cnt++; if (pc_addr !== 32'h10) $display("FAIL pre_halt: got %h expected %h", pc_addr, 32'h10); else pass_cnt++;
      halt_req = 1;
      tick();
      halt_req = 0;
      total_cnt++; if (pc_addr !== 32'h14 || pc_valid !== 1'b0) $display("FAIL halt: got %h/%b expected 14/0", pc_addr, pc_valid); else pass_cnt++;
      jump = 1; jump_target = 32'h300;
      tick();
      jump = 0;
      total_cnt++; if (pc_addr !== 32'h14 || pc_valid !== 1'b0) $display("FAIL halt_ignore: got %h/%b expected 14/0", pc_addr, pc_valid); else pass_cnt++;
      resume = 1; halt_req = 1;
      tick();
      clear_in();
      total_cnt++; if (pc_addr !== 32'h14 || pc_valid !== 1'b1) $display("FAIL resume: got %h/%b expected 14/1", pc_addr, pc_valid); else pass_cnt++;
      tick();
      total_cnt++; if (pc_addr !== 32'h18 || pc_valid !== 1'b1) $display("FAIL post_resume: got %h/%b expected 18/1", pc_addr, pc_valid); else pass_cnt++;
   endtask

   task automatic test_wrap();
      do_reset();
      total_cnt++; if (pc8 !== 8'hF8 || valid8 !== 1'b1) $display("FAIL wrap_start: got %h/%b expected f8/1", pc8, valid8); else pass_cnt++;
      tick();
      total_cnt++; if (pc8 !== 8'hFC || seq8 !== 8'h00) $display("FAIL wrap_seq: got %h/%h expected fc/00", pc8, seq8); else pass_cnt++;
      tick();
      total_cnt++; if (pc8 !== 8'h00 || trap8 !== 1'b0) $display("FAIL wrap: got %h/%b expected 00/0", pc8, trap8); else pass_cnt++;
   endtask

   task automatic test_reset_mid_stall();
      do_reset();
      jump = 1; jump_target = 32'h102;
      tick();
      jump = 0;
      stall = 1; jump = 1; jump_target = 32'h200;
      tick();
      total_cnt++; if (pend_valid !== 1'b1) $display("FAIL pend_before_rst: got %b expected 1", pend_valid); else pass_cnt++;
      rst_n = 0;
      #1;
      total_cnt++; if (pc_addr !== 32'h0 || pc_valid !== 1'b0 || trap !== 1'b0 || trap_epc !== 32'h0 || pend_valid !== 1'b0)
         $display("FAIL rst_mid_stall: got %h/%b/%b/%h/%b expected 0/0/0/0/0", pc_addr, pc_valid, trap, trap_epc, pend_valid);
      else pass_cnt++;
      clear_in();
      tick();
      rst_n = 1;
   endtask

   initial begin
      rst_n = 0;
      clear_in();
      test_reset();
      test_branch();
      test_jump_branch();
      test_stall();
      test_trap();
      test_halt();
      test_wrap();
      test_reset_mid_stall();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
